// File: rtl/alu_serial_sequencer.sv
// Bit-serial ALU sequencer: streams two latched operands LSB-first through an
// external 1-bit ALU slice, threading carry and running a sign pre-pass for SLT.
module alu_serial_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       aluOp,
  input  logic [WIDTH-1:0] operandA,
  input  logic [WIDTH-1:0] operandB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             sliceA,
  output logic             sliceB,
  output logic             sliceCarryIn,
  output logic             sliceLess,
  output logic [2:0]       sliceAluOp,
  input  logic             sliceResult,
  input  logic             sliceCarryOut
);

  localparam int unsigned IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b101;
  localparam logic [2:0] OP_SLT = 3'b111;

  typedef enum logic [1:0] {IDLE, SIGN, RUN, DONE} state_t;

  state_t           stateNow;
  state_t           stateNext;
  logic [WIDTH-1:0] aShift;
  logic [WIDTH-1:0] bShift;
  logic [WIDTH-1:0] aLatch;
  logic [WIDTH-1:0] bLatch;
  logic [2:0]       opReg;
  logic             carry;
  logic             lessBit;
  logic [IDX_W-1:0] bitIndex;
  logic             busyNext;
  logic             doneNext;
  logic             accept;
  logic             lastBit;

  // The done register is still high in the IDLE cycle that follows DONE; a
  // start seen there belongs to the completion cycle and is dropped.
  assign accept  = (stateNow == IDLE) && start && !done;
  assign lastBit = (bitIndex == LAST_IDX);
  assign zero    = (result == '0);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) stateNow <= IDLE;
    else       stateNow <= stateNext;
  end

  always_comb begin
    stateNext = stateNow;
    case (stateNow)
      IDLE: if (accept) stateNext = (aluOp == OP_SLT) ? SIGN : RUN;
      SIGN: if (lastBit) stateNext = RUN;
      RUN:  if (lastBit) stateNext = DONE;
      DONE: stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Slice drive is combinational from registers; busy/done next values are registered below.
  always_comb begin
    busyNext     = 1'b0;
    doneNext     = 1'b0;
    sliceA       = 1'b0;
    sliceB       = 1'b0;
    sliceCarryIn = 1'b0;
    sliceLess    = 1'b0;
    sliceAluOp   = 3'b000;
    case (stateNow)
      IDLE: busyNext = accept;
      SIGN: begin
        busyNext     = 1'b1;
        sliceA       = aShift[0];
        sliceB       = bShift[0];
        sliceCarryIn = carry;
        sliceAluOp   = OP_SUB;
      end
      RUN: begin
        busyNext     = 1'b1;
        sliceA       = aShift[0];
        sliceB       = bShift[0];
        sliceCarryIn = carry;
        sliceLess    = (bitIndex == '0) ? lessBit : 1'b0;
        sliceAluOp   = opReg;
      end
      DONE: doneNext = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= busyNext;
      done <= doneNext;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      aShift   <= '0;
      bShift   <= '0;
      aLatch   <= '0;
      bLatch   <= '0;
      opReg    <= '0;
      carry    <= 1'b0;
      lessBit  <= 1'b0;
      bitIndex <= '0;
      result   <= '0;
      overflow <= 1'b0;
    end else begin
      case (stateNow)
        IDLE: if (accept) begin
          aShift   <= operandA;
          bShift   <= operandB;
          aLatch   <= operandA;
          bLatch   <= operandB;
          opReg    <= aluOp;
          carry    <= aluOp[2];
          lessBit  <= 1'b0;
          bitIndex <= '0;
        end
        SIGN: begin
          if (lastBit) begin
            // MSB of a-b corrected by the signed-overflow term.
            lessBit  <= sliceResult ^ (carry ^ sliceCarryOut);
            aShift   <= aLatch;
            bShift   <= bLatch;
            carry    <= 1'b1;
            bitIndex <= '0;
          end else begin
            aShift   <= {1'b0, aShift[WIDTH-1:1]};
            bShift   <= {1'b0, bShift[WIDTH-1:1]};
            carry    <= sliceCarryOut;
            bitIndex <= bitIndex + IDX_W'(1);
          end
        end
        RUN: begin
          result   <= {sliceResult, result[WIDTH-1:1]};
          aShift   <= {1'b0, aShift[WIDTH-1:1]};
          bShift   <= {1'b0, bShift[WIDTH-1:1]};
          carry    <= sliceCarryOut;
          bitIndex <= bitIndex + IDX_W'(1);
          if (lastBit) begin
            overflow <= ((opReg == OP_ADD) || (opReg == OP_SUB)) ?
                        (carry ^ sliceCarryOut) : 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_serial_sequencer.sv
// Scoreboard bench for alu_serial_sequencer with a behavioural 1-bit slice
// attached and an arithmetic reference model.
module tb_alu_serial_sequencer;

  localparam int unsigned WIDTH = 32;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [2:0]       aluOp = 3'b000;
  logic [WIDTH-1:0] operandA = '0;
  logic [WIDTH-1:0] operandB = '0;
  logic             busy, done, zero, overflow;
  logic [WIDTH-1:0] result;
  logic             sliceA, sliceB, sliceCarryIn, sliceLess;
  logic [2:0]       sliceAluOp;
  logic             sliceResult, sliceCarryOut, bEff;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    int          lat;
    int          acceptCycle;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   errors = 0;
  int   checks = 0;
  int   cycle = 0;
  int   doneCount = 0;

  alu_serial_sequencer #(.WIDTH(WIDTH)) dut (
    .clock(clock), .reset(reset), .start(start), .aluOp(aluOp),
    .operandA(operandA), .operandB(operandB), .busy(busy), .done(done),
    .result(result), .zero(zero), .overflow(overflow),
    .sliceA(sliceA), .sliceB(sliceB), .sliceCarryIn(sliceCarryIn),
    .sliceLess(sliceLess), .sliceAluOp(sliceAluOp),
    .sliceResult(sliceResult), .sliceCarryOut(sliceCarryOut)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cycle <= cycle + 1;

  // 1-bit ALU slice: bit 2 inverts b, bits [1:0] pick AND/sum/OR/less.
  always_comb begin
    bEff          = sliceB ^ sliceAluOp[2];
    sliceCarryOut = (sliceA & bEff) | (sliceA & sliceCarryIn) | (bEff & sliceCarryIn);
    case (sliceAluOp[1:0])
      2'b00:   sliceResult = sliceA & bEff;
      2'b01:   sliceResult = sliceA ^ bEff ^ sliceCarryIn;
      2'b10:   sliceResult = sliceA | bEff;
      default: sliceResult = sliceLess;
    endcase
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic o);
    o = 1'b0;
    case (op)
      3'b000: r = a & b;
      3'b010: r = a | b;
      3'b001: begin r = a + b; o = (a[31] == b[31]) && (r[31] != a[31]); end
      3'b101: begin r = a - b; o = (a[31] != b[31]) && (r[31] != a[31]); end
      default: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    endcase
  endfunction

  // Monitor: pops the oldest expectation on every done pulse.
  initial begin
    bit   doneSeen;
    exp_t e;
    doneSeen = 0;
    forever begin
      @(negedge clock);
      if (doneSeen) check("done_width", 32'(done), 32'd0);
      doneSeen = 0;
      if (done) begin
        doneCount++;
        doneSeen = 1;
        if (expQ.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = expQ.pop_front();
          check({e.name, "_result"}, result, e.res);
          check({e.name, "_zero"}, 32'(zero), 32'(e.res == 32'd0));
          check({e.name, "_overflow"}, 32'(overflow), 32'(e.ovf));
          check({e.name, "_latency"}, 32'(cycle - e.acceptCycle), 32'(e.lat));
        end
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    exp_t e;
    @(negedge clock);
    start = 1'b1; aluOp = op; operandA = a; operandB = b;
    @(negedge clock);
    start = 1'b0;
    model(op, a, b, e.res, e.ovf);
    e.lat = (op == 3'b111) ? 65 : 33;
    e.acceptCycle = cycle;
    e.name = name;
    expQ.push_back(e);
    check({name, "_busy_rise"}, 32'(busy), 32'd1);
    check({name, "_slice_op"}, 32'(sliceAluOp), 32'((op == 3'b111) ? 3'b101 : op));
  endtask

  task automatic waitDone(input int already, input int lat, input string name);
    int n;
    int bc;
    n = 0;
    bc = already;
    while (!done && n < 200) begin
      @(negedge clock);
      n++;
      if (busy) bc++;
    end
    if (!done) check({name, "_timeout"}, 32'd0, 32'd1);
    else check({name, "_busy_cycles"}, 32'(bc), 32'(lat));
  endtask

  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string name);
    issue(op, a, b, name);
    waitDone(1, (op == 3'b111) ? 65 : 33, name);
  endtask

  initial begin
    logic [2:0]  ops [5];
    logic [31:0] corners [4];
    logic [31:0] ra, rb;
    int          dc0;
    ops = '{3'b000, 3'b010, 3'b001, 3'b101, 3'b111};
    corners = '{32'h0, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    repeat (3) @(negedge clock);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", 32'(zero), 32'd1);
    check("rst_overflow", 32'(overflow), 32'd0);
    check("rst_slice", {24'd0, sliceA, sliceB, sliceCarryIn, sliceLess, 1'b0, sliceAluOp}, 32'd0);
    reset = 1'b0;

    runOp(3'b001, 32'd7, 32'd5, "add_7_5");
    runOp(3'b001, 32'h7FFF_FFFF, 32'd1, "add_ovf");
    runOp(3'b101, 32'h8000_0000, 32'd1, "sub_ovf");
    runOp(3'b101, 32'd5, 32'd5, "sub_zero");
    runOp(3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, "and");
    runOp(3'b010, 32'hF0F0_F0F0, 32'hFF00_FF00, "or");
    runOp(3'b111, 32'hFFFF_FFFF, 32'd1, "slt_neg_pos");
    runOp(3'b111, 32'd1, 32'hFFFF_FFFF, "slt_pos_neg");
    runOp(3'b111, 32'h8000_0000, 32'h7FFF_FFFF, "slt_ovf");

    // start during an operation must be ignored
    dc0 = doneCount;
    issue(3'b001, 32'd100, 32'd23, "add_busy_start");
    repeat (9) @(negedge clock);
    start = 1'b1; aluOp = 3'b010; operandA = 32'hDEAD_BEEF; operandB = 32'h1234_5678;
    @(negedge clock);
    start = 1'b0;
    waitDone(11, 33, "add_busy_start");
    // start in the done cycle must be ignored
    start = 1'b1; aluOp = 3'b000;
    @(negedge clock);
    start = 1'b0;
    check("done_cycle_start_busy", 32'(busy), 32'd0);
    repeat (70) @(negedge clock);
    check("single_done", 32'(doneCount), 32'(dc0 + 1));

    // asynchronous abort mid-SUB
    issue(3'b101, 32'h1234_5678, 32'h0000_1111, "sub_abort");
    repeat (19) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_zero", 32'(zero), 32'd1);
    void'(expQ.pop_back());
    dc0 = doneCount;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    repeat (40) @(negedge clock);
    check("abort_no_done", 32'(doneCount), 32'(dc0));
    runOp(3'b001, 32'd1, 32'd1, "add_after_reset");

    for (int i = 0; i < 30; i++) begin
      ra = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 3)] : 32'($urandom);
      runOp(ops[$urandom_range(0, 4)], ra, rb, "rand");
    end

    repeat (5) @(negedge clock);
    check("queue_empty", 32'(expQ.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
